// File: rtl/lc3_writeback.sv
// lc3_writeback: writeback stage. Selects the result (ALU, memory or PC), writes it into the
//   register file, updates the {N,Z,P} condition codes and raises a one-cycle retire strobe.
// Latency: RF/psr are visible one cycle after the commit edge. wb_* are registered at that edge.
//   Read ports are combinational, with optional same-cycle forwarding of the write.
// Backpressure: none. Every enabled, legal cycle commits. An illegal select sets a sticky error.
// Ports: clock, reset (sync, active-low); enable_writeback, W_Control_in, aluout, pcout,
//   memout and dr carry the write. sr1/sr2 -> VSR1/VSR2 are the read ports. psr holds the
//   condition codes. wb_valid/wb_dr/wb_data form the retire strobe. wb_err is the sticky error.

module lc3_writeback #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int BYPASS = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable_writeback,
   input  logic [1:0]        W_Control_in,
   input  logic [DATA_W-1:0] aluout,
   input  logic [DATA_W-1:0] pcout,
   input  logic [DATA_W-1:0] memout,
   input  logic [2:0]        dr,
   input  logic [2:0]        sr1,
   input  logic [2:0]        sr2,
   output logic [DATA_W-1:0] VSR1,
   output logic [DATA_W-1:0] VSR2,
   output logic [2:0]        psr,
   output logic              wb_valid,
   output logic [2:0]        wb_dr,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_err
);

   logic [DATA_W-1:0] rf [NREG];
   logic [DATA_W-1:0] wb_val;
   logic [2:0]        psr_nxt;
   logic              commit;
   logic              illegal;

   assign commit  = enable_writeback && (W_Control_in != 2'd3);
   assign illegal = enable_writeback && (W_Control_in == 2'd3);

   always_comb begin
      wb_val = '0;
      case (W_Control_in)
         2'd0:    wb_val = aluout;
         2'd1:    wb_val = memout;
         2'd2:    wb_val = pcout;
         default: wb_val = '0;   // illegal select: never committed or forwarded
      endcase
   end

   // Exactly one of N, Z, P is set for any value.
   assign psr_nxt = {wb_val[DATA_W-1],
                     (wb_val == '0),
                     (!wb_val[DATA_W-1] && (wb_val != '0))};

   // Each read port forwards independently, so dr == sr1 == sr2 gives both ports the same value.
   assign VSR1 = ((BYPASS != 0) && commit && (sr1 == dr)) ? wb_val : rf[sr1];
   assign VSR2 = ((BYPASS != 0) && commit && (sr2 == dr)) ? wb_val : rf[sr2];

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            rf[i] <= '0;
         end
         psr      <= 3'b010;
         wb_valid <= 1'b0;
         wb_dr    <= '0;
         wb_data  <= '0;
         wb_err   <= 1'b0;
      end else begin
         wb_valid <= commit;
         if (commit) begin
            rf[dr]  <= wb_val;
            psr     <= psr_nxt;
            wb_dr   <= dr;
            wb_data <= wb_val;
         end
         if (illegal) begin
            wb_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lc3_writeback.sv
module tb_lc3_writeback;

   logic        clock;
   logic        reset;
   logic        enable_writeback;
   logic [1:0]  W_Control_in;
   logic [15:0] aluout, pcout, memout;
   logic [2:0]  dr, sr1, sr2;

   logic [15:0] VSR1, VSR2, wb_data;
   logic [2:0]  psr, wb_dr;
   logic        wb_valid, wb_err;

   logic [15:0] nb_VSR1, nb_VSR2, nb_wb_data;
   logic [2:0]  nb_psr, nb_wb_dr;
   logic        nb_wb_valid, nb_wb_err;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model state
   logic [15:0] m_rf [8];
   logic [2:0]  m_psr;
   logic        m_valid, m_err;
   logic [2:0]  m_dr;
   logic [15:0] m_data;

   lc3_writeback #(.DATA_W(16), .NREG(8), .BYPASS(1)) dut (
      .clock(clock), .reset(reset), .enable_writeback(enable_writeback),
      .W_Control_in(W_Control_in), .aluout(aluout), .pcout(pcout), .memout(memout),
      .dr(dr), .sr1(sr1), .sr2(sr2), .VSR1(VSR1), .VSR2(VSR2), .psr(psr),
      .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_data(wb_data), .wb_err(wb_err));

   lc3_writeback #(.DATA_W(16), .NREG(8), .BYPASS(0)) dut_nb (
      .clock(clock), .reset(reset), .enable_writeback(enable_writeback),
      .W_Control_in(W_Control_in), .aluout(aluout), .pcout(pcout), .memout(memout),
      .dr(dr), .sr1(sr1), .sr2(sr2), .VSR1(nb_VSR1), .VSR2(nb_VSR2), .psr(nb_psr),
      .wb_valid(nb_wb_valid), .wb_dr(nb_wb_dr), .wb_data(nb_wb_data), .wb_err(nb_wb_err));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] sel_value();
      if (W_Control_in == 2'd0) return aluout;
      if (W_Control_in == 2'd1) return memout;
      return pcout;
   endfunction

   function automatic logic [2:0] cc_of(input logic [15:0] v);
      if (v == 16'h0000) return 3'b010;
      if (v >= 16'h8000) return 3'b100;
      return 3'b001;
   endfunction

   function automatic logic [15:0] exp_read(input logic [2:0] sr, input bit bypass);
      if (bypass && enable_writeback && W_Control_in != 2'd3 && sr == dr) return sel_value();
      return m_rf[sr];
   endfunction

   // Apply what the design will see at the next rising edge to the model, then step past it.
   task automatic tick();
      if (!reset) begin
         for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
         m_psr = 3'b010; m_valid = 1'b0; m_dr = 3'd0; m_data = 16'h0000; m_err = 1'b0;
      end else if (enable_writeback && W_Control_in != 2'd3) begin
         m_rf[dr] = sel_value();
         m_psr    = cc_of(sel_value());
         m_valid  = 1'b1;
         m_dr     = dr;
         m_data   = sel_value();
      end else begin
         m_valid = 1'b0;
         if (enable_writeback) m_err = 1'b1;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; enable_writeback = 1'b1; W_Control_in = 2'd0;
      aluout = 16'h1234; pcout = 16'h0; memout = 16'h0; dr = 3'd3; sr1 = 3'd3; sr2 = 3'd0;
      tick();
      tick();
      reset = 1'b1; enable_writeback = 1'b0;
      #1;
      n_cmp++; if (psr !== 3'b010) begin n_fail++;
         $display("FAIL reset_psr: got %b want 010", psr); end
      n_cmp++; if (wb_valid !== 1'b0) begin n_fail++;
         $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
      n_cmp++; if (wb_err !== 1'b0 || wb_dr !== 3'd0 || wb_data !== 16'h0) begin n_fail++;
         $display("FAIL reset_wb_regs: err %b dr %0d data %h want 0/0/0", wb_err, wb_dr, wb_data); end
      n_cmp++; if (VSR1 !== 16'h0000) begin n_fail++;
         $display("FAIL reset_vsr1_r3: got %h want 0000", VSR1); end
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i); sr2 = 3'(7 - i);
         #1;
         n_cmp++; if (VSR1 !== 16'h0 || VSR2 !== 16'h0) begin n_fail++;
            $display("FAIL reset_rf%0d: got %h/%h want 0000", i, VSR1, VSR2); end
      end
   endtask

   task automatic test_alu_write();
      enable_writeback = 1'b1; W_Control_in = 2'd0; aluout = 16'h8001; dr = 3'd5;
      sr1 = 3'd5; sr2 = 3'd0;
      tick();
      enable_writeback = 1'b0;
      #1;
      n_cmp++; if (VSR1 !== 16'h8001) begin n_fail++;
         $display("FAIL alu_rf5: got %h want 8001", VSR1); end
      n_cmp++; if (psr !== 3'b100) begin n_fail++;
         $display("FAIL alu_psr: got %b want 100", psr); end
      n_cmp++; if (wb_valid !== 1'b1 || wb_dr !== 3'd5 || wb_data !== 16'h8001) begin n_fail++;
         $display("FAIL alu_retire: got v%b dr%0d %h want v1 dr5 8001", wb_valid, wb_dr, wb_data); end
      tick();
      n_cmp++; if (wb_valid !== 1'b0 || wb_dr !== 3'd5 || wb_data !== 16'h8001) begin n_fail++;
         $display("FAIL alu_strobe_end: got v%b dr%0d %h want v0 dr5 8001", wb_valid, wb_dr, wb_data); end
   endtask

   task automatic test_source_select();
      enable_writeback = 1'b1; W_Control_in = 2'd1; memout = 16'h0000; dr = 3'd1;
      aluout = 16'h5555; pcout = 16'h6666;
      tick();
      n_cmp++; if (wb_valid !== 1'b1 || psr !== 3'b010 || wb_data !== 16'h0000) begin n_fail++;
         $display("FAIL sel_mem: got v%b psr%b %h want v1 psr010 0000", wb_valid, psr, wb_data); end
      W_Control_in = 2'd2; pcout = 16'h3002; dr = 3'd2; memout = 16'h7777;
      tick();
      n_cmp++; if (wb_valid !== 1'b1 || psr !== 3'b001 || wb_dr !== 3'd2) begin n_fail++;
         $display("FAIL sel_pc: got v%b psr%b dr%0d want v1 psr001 dr2", wb_valid, psr, wb_dr); end
      enable_writeback = 1'b0; sr1 = 3'd1; sr2 = 3'd2;
      #1;
      n_cmp++; if (VSR1 !== 16'h0000 || VSR2 !== 16'h3002) begin n_fail++;
         $display("FAIL sel_rf: got %h/%h want 0000/3002", VSR1, VSR2); end
   endtask

   task automatic test_bypass();
      enable_writeback = 1'b1; W_Control_in = 2'd0; aluout = 16'h1111; dr = 3'd4;
      tick();
      aluout = 16'h00AA; sr1 = 3'd4; sr2 = 3'd4;
      #1;
      n_cmp++; if (VSR1 !== 16'h00AA || VSR2 !== 16'h00AA) begin n_fail++;
         $display("FAIL bypass_on: got %h/%h want 00AA/00AA", VSR1, VSR2); end
      n_cmp++; if (nb_VSR1 !== 16'h1111 || nb_VSR2 !== 16'h1111) begin n_fail++;
         $display("FAIL bypass_off: got %h/%h want 1111/1111", nb_VSR1, nb_VSR2); end
      tick();
      enable_writeback = 1'b0;
      #1;
      n_cmp++; if (nb_VSR1 !== 16'h00AA || VSR2 !== 16'h00AA) begin n_fail++;
         $display("FAIL bypass_after: got %h/%h want 00AA/00AA", nb_VSR1, VSR2); end
   endtask

   task automatic test_illegal();
      logic [2:0] psr_before;
      enable_writeback = 1'b1; W_Control_in = 2'd0; aluout = 16'h0123; dr = 3'd6;
      tick();
      psr_before = cc_of(16'h0123);
      W_Control_in = 2'd3; aluout = 16'hFFFF; sr1 = 3'd6; sr2 = 3'd6;
      #1;
      n_cmp++; if (VSR1 !== 16'h0123) begin n_fail++;
         $display("FAIL illegal_no_fwd: got %h want 0123", VSR1); end
      tick();
      enable_writeback = 1'b0;
      #1;
      n_cmp++; if (VSR2 !== 16'h0123 || psr !== psr_before) begin n_fail++;
         $display("FAIL illegal_hold: got %h psr%b want 0123 psr%b", VSR2, psr, psr_before); end
      n_cmp++; if (wb_valid !== 1'b0 || wb_err !== 1'b1) begin n_fail++;
         $display("FAIL illegal_flags: got v%b err%b want v0 err1", wb_valid, wb_err); end
      W_Control_in = 2'd0;
      tick(); tick(); tick();
      n_cmp++; if (wb_err !== 1'b1) begin n_fail++;
         $display("FAIL illegal_sticky: got %b want 1", wb_err); end
   endtask

   task automatic test_hold_reset();
      enable_writeback = 1'b1; W_Control_in = 2'd3;
      tick();
      W_Control_in = 2'd0; aluout = 16'h7FFF; dr = 3'd7;
      tick();
      enable_writeback = 1'b0; aluout = 16'h0000; dr = 3'd0; sr1 = 3'd7;
      tick(); tick(); tick();
      n_cmp++; if (VSR1 !== 16'h7FFF || psr !== 3'b001 || wb_err !== 1'b1) begin n_fail++;
         $display("FAIL hold: got %h psr%b err%b want 7FFF psr001 err1", VSR1, psr, wb_err); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      n_cmp++; if (VSR1 !== 16'h0000 || psr !== 3'b010 || wb_err !== 1'b0) begin n_fail++;
         $display("FAIL midreset: got %h psr%b err%b want 0000 psr010 err0", VSR1, psr, wb_err); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         reset            = ($urandom_range(0, 39) != 0);
         enable_writeback = ($urandom_range(0, 3) != 0);
         W_Control_in     = 2'($urandom_range(0, 3));
         aluout = 16'($urandom); memout = 16'($urandom); pcout = 16'($urandom);
         if ($urandom_range(0, 7) == 0) aluout = 16'h0000;
         dr  = 3'($urandom_range(0, 7));
         sr1 = ($urandom_range(0, 2) == 0) ? dr : 3'($urandom_range(0, 7));
         sr2 = ($urandom_range(0, 2) == 0) ? dr : 3'($urandom_range(0, 7));
         #1;
         n_cmp++; if (VSR1 !== exp_read(sr1, 1'b1) || VSR2 !== exp_read(sr2, 1'b1)) begin
            n_fail++; $display("FAIL rnd_read_byp[%0d]: got %h/%h want %h/%h", n, VSR1, VSR2,
                               exp_read(sr1, 1'b1), exp_read(sr2, 1'b1)); end
         n_cmp++; if (nb_VSR1 !== exp_read(sr1, 1'b0) || nb_VSR2 !== exp_read(sr2, 1'b0)) begin
            n_fail++; $display("FAIL rnd_read_nobyp[%0d]: got %h/%h want %h/%h", n, nb_VSR1,
                               nb_VSR2, exp_read(sr1, 1'b0), exp_read(sr2, 1'b0)); end
         tick();
         n_cmp++; if (psr !== m_psr || wb_valid !== m_valid || wb_err !== m_err) begin
            n_fail++; $display("FAIL rnd_state[%0d]: got psr%b v%b e%b want psr%b v%b e%b", n,
                               psr, wb_valid, wb_err, m_psr, m_valid, m_err); end
         n_cmp++; if (wb_dr !== m_dr || wb_data !== m_data) begin
            n_fail++; $display("FAIL rnd_retire[%0d]: got dr%0d %h want dr%0d %h", n,
                               wb_dr, wb_data, m_dr, m_data); end
         n_cmp++; if (nb_psr !== m_psr || nb_wb_data !== m_data) begin
            n_fail++; $display("FAIL rnd_nobyp_state[%0d]: got psr%b %h want psr%b %h", n,
                               nb_psr, nb_wb_data, m_psr, m_data); end
      end
   endtask

   task automatic test_back_to_back();
      reset = 1'b1; enable_writeback = 1'b1;
      for (int i = 0; i < 4; i++) begin
         W_Control_in = 2'd0; aluout = 16'(16'h0100 * i + 1); dr = 3'(i);
         tick();
         n_cmp++; if (wb_valid !== 1'b1 || wb_data !== aluout || wb_dr !== 3'(i)) begin
            n_fail++; $display("FAIL b2b[%0d]: got v%b %h dr%0d want v1 %h dr%0d", i,
                               wb_valid, wb_data, wb_dr, aluout, i); end
      end
      enable_writeback = 1'b0;
      tick();
      n_cmp++; if (wb_valid !== 1'b0) begin n_fail++;
         $display("FAIL b2b_end: got %b want 0", wb_valid); end
   endtask

   initial begin
      test_reset();
      test_alu_write();
      test_source_select();
      test_bypass();
      test_illegal();
      test_hold_reset();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
